enemy_spawn_scheduler: RTL
==========================

Name: enemy_spawn_scheduler

Overview:
Game-flow controller for the racing display. Runs the IDLE/RUN/CRASH/OVER game state machine and decides when and in which lane each enemy-car slot is launched. Ramps difficulty by raising a level counter, which shortens the spawn interval and the enemy step divider. Sits between the frame/step tick source and the enemy sprite instances; consumes collision and slot-occupancy status.

Parameters:
NUM_SLOTS, 4, number of enemy sprite slots managed (2..8)
BASE_INTERVAL, 40, ticks between spawn attempts at level 0
INTERVAL_STEP, 4, interval reduction per level
MIN_INTERVAL, 8, floor for the spawn interval
BASE_DIV, 16, enemy step divider at level 0
LEVEL_SPAWNS, 8, successful spawns per level increment
MAX_LEVEL, 15, level saturation value
CRASH_TICKS, 60, ticks spent in CRASH before OVER
LFSR_SEED, 8'hA5, LFSR value after reset

Ports:
clk50mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; begins a game from IDLE or OVER
tick  in  1  one-cycle step strobe (game time base)
collision  in  1  level; player/enemy overlap
slot_busy  in  NUM_SLOTS  bit i = enemy slot i on screen
spawn_en  out  NUM_SLOTS  one-hot, one-cycle pulse that loads slot i at top of track
spawn_lane  out  2  0=left, 1=center, 2=right; valid when spawn_en != 0
step_div  out  5  current enemy movement divider
level  out  4  current difficulty level
score  out  16  enemies passed this game
state  out  2  0=IDLE 1=RUN 2=CRASH 3=OVER
game_over  out  1  high while state==OVER

Behaviour:
- Synchronous active-high reset, highest priority in any state: state=IDLE, spawn_en=0, spawn_lane=0, level=0, score=0, step_div=BASE_DIV, tick counters=0, pending=0, rr_ptr=0, last_lane=1, lfsr=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clock in every state except reset.
- IDLE: start -> RUN; on that entry edge clear level, score, counters, pending; step_div=BASE_DIV.
- RUN: interval = max(BASE_INTERVAL - level*INTERVAL_STEP, MIN_INTERVAL), computed at 16-bit width with no underflow. tick_cnt increments on tick; at tick_cnt==interval-1 with tick: tick_cnt->0, pending=1.
- Spawn issue, with pending=1: search slot_busy for a free slot, round-robin starting at rr_ptr. The first free slot j gets spawn_en[j]=1 for exactly one cycle (registered, one clock after the decision cycle). rr_ptr=j+1 mod NUM_SLOTS; pending=0.
- All slots busy: pending stays 1 and is re-checked every clock. Pending attempts do not queue; a second interval expiry while pending is dropped.
- Lane: cand = lfsr[1:0]; 3 maps to 1. If cand==last_lane, lane=(cand+1) mod 3. last_lane updates on issue.
- spawn counter increments per issued spawn. On reaching LEVEL_SPAWNS: counter->0, level++ saturating at MAX_LEVEL. step_div = max(BASE_DIV - level, 1), updated the cycle after level changes.
- score: +1 per falling edge of any slot_busy bit while in RUN. Multiple bits falling in one cycle add the popcount. Saturates at 16'hFFFF.
- collision in RUN -> CRASH next cycle; collision beats a same-cycle spawn (no spawn_en, pending cleared).
- CRASH: spawn_en forced 0; counts CRASH_TICKS ticks then -> OVER. level/score frozen.
- OVER: game_over=1; start -> RUN with same clears as IDLE->RUN. collision ignored outside RUN.
- spawn_en never has more than one bit set; it is never asserted outside RUN.

Test Plan:
- Reset then idle 100 ticks, start=0 -> state=0, spawn_en never asserted, step_div=16, lfsr reloaded to A5.
- start, slot_busy=0, 40 ticks -> single spawn_en=0001 one clock after 40th tick; next attempt after another 40 ticks on slot 1 (0010); lanes of consecutive spawns differ.
- slot_busy=1111 at interval expiry, release slot 2 after 500 clocks -> spawn_en=0100 exactly one clock after release; only one spawn despite further expiries while blocked.
- 8 spawns -> level=1, interval=36, step_div=15. Drive to 15 levels -> level saturates at 15, interval=8, step_div=1.
- slot_busy bits 0 and 3 fall in the same cycle -> score +2. collision coincident with expiry -> no spawn, state=CRASH; after 60 ticks state=OVER, game_over=1.
- reset asserted mid-RUN with pending=1 -> next cycle state=IDLE, all outputs at reset values, no spawn_en.

Source files
------------

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
// Game-flow controller for the racing display. Runs the IDLE/RUN/CRASH/OVER
// state machine, launches enemy cars into free sprite slots on a
// level-dependent interval, picks the lane, ramps difficulty and keeps score.
// Ports:
//   clk50mhz    system clock
//   reset       synchronous, active-high reset
//   start       level; starts a game from IDLE or OVER
//   tick        one-cycle game time-base strobe
//   collision   level; player/enemy overlap
//   slot_busy   bit i high while enemy slot i is on screen
//   spawn_en    one-hot one-cycle pulse loading slot i at the top of track
//   spawn_lane  0=left 1=center 2=right, valid with spawn_en
//   step_div    enemy movement divider for the current level
//   level       difficulty level
//   score       enemies passed this game
//   state       0=IDLE 1=RUN 2=CRASH 3=OVER
//   game_over   high while in OVER
module enemy_spawn_scheduler #(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned BASE_INTERVAL = 40,
  parameter int unsigned INTERVAL_STEP = 4,
  parameter int unsigned MIN_INTERVAL  = 8,
  parameter int unsigned BASE_DIV      = 16,
  parameter int unsigned LEVEL_SPAWNS  = 8,
  parameter int unsigned MAX_LEVEL     = 15,
  parameter int unsigned CRASH_TICKS   = 60,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 clk50mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic                 collision,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] spawn_en,
  output logic [1:0]           spawn_lane,
  output logic [4:0]           step_div,
  output logic [3:0]           level,
  output logic [15:0]          score,
  output logic [1:0]           state,
  output logic                 game_over
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned POP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e               state_q;
  logic [NUM_SLOTS-1:0] spawn_en_q;
  logic [NUM_SLOTS-1:0] busy_prev_q;
  logic [1:0]           spawn_lane_q;
  logic [1:0]           last_lane_q;
  logic [4:0]           step_div_q;
  logic [3:0]           level_q;
  logic [15:0]          score_q;
  logic                 game_over_q;
  logic [CNT_W-1:0]     tick_cnt_q;
  logic [CNT_W-1:0]     crash_cnt_q;
  logic [CNT_W-1:0]     spawn_cnt_q;
  logic                 pending_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [7:0]           lfsr_q;

  logic [CNT_W-1:0]     level_prod_c;
  logic [CNT_W-1:0]     interval_c;
  logic [4:0]           step_div_c;
  logic                 expiry_c;
  logic [NUM_SLOTS-1:0] free_rot_c;
  logic                 found_c;
  logic [PTR_W-1:0]     offs_c;
  logic [SUM_W-1:0]     slot_sum_c;
  logic [PTR_W-1:0]     slot_c;
  logic [SUM_W-1:0]     rr_sum_c;
  logic [PTR_W-1:0]     rr_next_c;
  logic [NUM_SLOTS-1:0] spawn_vec_c;
  logic [1:0]           cand_c;
  logic [1:0]           lane_c;
  logic                 issue_c;
  logic [NUM_SLOTS-1:0] fall_c;
  logic [POP_W-1:0]     fall_cnt_c;
  logic [16:0]          score_sum_c;
  logic [15:0]          score_next_c;
  logic                 lfsr_fb_c;

  // Spawn interval for the current level, floored at MIN_INTERVAL without underflow.
  always_comb begin
    level_prod_c = CNT_W'(level_q) * CNT_W'(INTERVAL_STEP);
    if (32'(level_prod_c) + MIN_INTERVAL >= BASE_INTERVAL) begin
      interval_c = CNT_W'(MIN_INTERVAL);
    end else begin
      interval_c = CNT_W'(BASE_INTERVAL) - level_prod_c;
    end
  end

  // Enemy step divider for the current level, floored at 1.
  always_comb begin
    if (32'(level_q) + 32'd1 >= BASE_DIV) begin
      step_div_c = 5'd1;
    end else begin
      step_div_c = 5'(BASE_DIV - 32'(level_q));
    end
  end

  // >= so a shrunken interval after a level-up cannot strand the counter above it.
  assign expiry_c = (state_q == ST_RUN) && tick &&
                    (tick_cnt_q >= interval_c - CNT_W'(1));

  // Round-robin free-slot search: rotate the free mask so rr_ptr sits at bit 0.
  always_comb begin
    free_rot_c = NUM_SLOTS'(~{slot_busy, slot_busy} >> rr_ptr_q);
    found_c    = |free_rot_c;
    offs_c     = '0;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (free_rot_c[k]) begin
        offs_c = PTR_W'(k);
      end
    end
    slot_sum_c = {1'b0, rr_ptr_q} + {1'b0, offs_c};
    if (slot_sum_c >= SUM_W'(NUM_SLOTS)) begin
      slot_sum_c = slot_sum_c - SUM_W'(NUM_SLOTS);
    end
    slot_c   = slot_sum_c[PTR_W-1:0];
    rr_sum_c = {1'b0, slot_c} + SUM_W'(1);
    if (rr_sum_c >= SUM_W'(NUM_SLOTS)) begin
      rr_sum_c = rr_sum_c - SUM_W'(NUM_SLOTS);
    end
    rr_next_c   = rr_sum_c[PTR_W-1:0];
    spawn_vec_c = NUM_SLOTS'(1) << slot_c;
  end

  // Lane pick: LFSR candidate (3 folds to center), bumped if it repeats the last lane.
  always_comb begin
    cand_c = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    if (cand_c == last_lane_q) begin
      lane_c = (cand_c == 2'd2) ? 2'd0 : cand_c + 2'd1;
    end else begin
      lane_c = cand_c;
    end
  end

  // A pending or just-expired attempt issues into a free slot unless a crash wins.
  assign issue_c = (state_q == ST_RUN) && !collision &&
                   (pending_q || expiry_c) && found_c;

  // Score: count slots that left the screen this cycle, saturating.
  always_comb begin
    fall_c     = busy_prev_q & ~slot_busy;
    fall_cnt_c = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      fall_cnt_c = fall_cnt_c + POP_W'(fall_c[k]);
    end
    score_sum_c  = {1'b0, score_q} + 17'(fall_cnt_c);
    score_next_c = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
  end

  assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Game FSM with all registered state and outputs.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      spawn_en_q   <= '0;
      spawn_lane_q <= 2'd0;
      last_lane_q  <= 2'd1;
      level_q      <= 4'd0;
      score_q      <= 16'd0;
      step_div_q   <= 5'(BASE_DIV);
      game_over_q  <= 1'b0;
      tick_cnt_q   <= '0;
      crash_cnt_q  <= '0;
      spawn_cnt_q  <= '0;
      pending_q    <= 1'b0;
      rr_ptr_q     <= '0;
      lfsr_q       <= LFSR_SEED;
      busy_prev_q  <= '0;
    end else begin
      lfsr_q      <= {lfsr_q[6:0], lfsr_fb_c};
      busy_prev_q <= slot_busy;
      spawn_en_q  <= '0;
      step_div_q  <= step_div_c;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q     <= ST_RUN;
            game_over_q <= 1'b0;
            level_q     <= 4'd0;
            score_q     <= 16'd0;
            tick_cnt_q  <= '0;
            crash_cnt_q <= '0;
            spawn_cnt_q <= '0;
            pending_q   <= 1'b0;
            step_div_q  <= 5'(BASE_DIV);
          end
        end
        ST_RUN: begin
          score_q <= score_next_c;
          if (collision) begin
            state_q     <= ST_CRASH;
            pending_q   <= 1'b0;
            crash_cnt_q <= '0;
          end else begin
            if (tick) begin
              tick_cnt_q <= expiry_c ? '0 : tick_cnt_q + CNT_W'(1);
            end
            if (issue_c) begin
              spawn_en_q   <= spawn_vec_c;
              spawn_lane_q <= lane_c;
              last_lane_q  <= lane_c;
              rr_ptr_q     <= rr_next_c;
              pending_q    <= 1'b0;
              if (spawn_cnt_q >= CNT_W'(LEVEL_SPAWNS - 1)) begin
                spawn_cnt_q <= '0;
                if (level_q != 4'(MAX_LEVEL)) begin
                  level_q <= level_q + 4'd1;
                end
              end else begin
                spawn_cnt_q <= spawn_cnt_q + CNT_W'(1);
              end
            end else begin
              // A further expiry while already pending is simply absorbed.
              pending_q <= pending_q | expiry_c;
            end
          end
        end
        ST_CRASH: begin
          if (tick) begin
            if (crash_cnt_q >= CNT_W'(CRASH_TICKS - 1)) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              crash_cnt_q <= crash_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spawn_en   = spawn_en_q;
  assign spawn_lane = spawn_lane_q;
  assign step_div   = step_div_q;
  assign level      = level_q;
  assign score      = score_q;
  assign state      = state_q;
  assign game_over  = game_over_q;

endmodule
